// File: rtl/cpu_defs.sv
// Shared definitions for the ex_stage slice: ALU op codes, pipeline bus
// widths, ID->EX bus field offsets and the divider state encoding.
package cpu_defs;

   localparam int ID2EX_BUS_W = 140;
   localparam int EX2ME_BUS_W = 71;
   localparam int DIV_ITER    = 32;

   // ID->EX bus field LSB positions
   localparam int ID_PC_LSB      = 108;
   localparam int ID_OP_LSB      = 104;
   localparam int ID_SRC1_LSB    = 72;
   localparam int ID_SRC2_LSB    = 40;
   localparam int ID_RKD_LSB     = 8;
   localparam int ID_MEM_WE_BIT  = 7;
   localparam int ID_RES_MEM_BIT = 6;
   localparam int ID_GR_WE_BIT   = 5;

   typedef enum logic [3:0] {
      ALU_OP_ADD  = 4'd0,  ALU_OP_SUB  = 4'd1,  ALU_OP_SLT  = 4'd2,  ALU_OP_SLTU = 4'd3,
      ALU_OP_AND  = 4'd4,  ALU_OP_OR   = 4'd5,  ALU_OP_NOR  = 4'd6,  ALU_OP_XOR  = 4'd7,
      ALU_OP_SLL  = 4'd8,  ALU_OP_SRL  = 4'd9,  ALU_OP_SRA  = 4'd10, ALU_OP_LUI  = 4'd11,
      ALU_OP_DIV  = 4'd12, ALU_OP_MOD  = 4'd13, ALU_OP_DIVU = 4'd14, ALU_OP_MODU = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input alu_op_e op);
      return op[3:2] == 2'b11;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-side bundle of ex_stage: ID->EX handshake/bus, EX->ME
// handshake/bus, hazard taps and the data SRAM request.
// master: the execute stage itself.  slave: its environment (ID, ME, SRAM).
interface ex_stage_if;
   import cpu_defs::*;

   logic                   ID_to_EX_Valid;
   logic [ID2EX_BUS_W-1:0] ID_to_EX_Bus;
   logic                   EX_Allow_in;
   logic                   ME_Allow_in;
   logic                   EX_to_ME_Valid;
   logic [EX2ME_BUS_W-1:0] EX_to_ME_Bus;
   logic [4:0]             EX_dest;
   logic                   EX_is_load;
   logic                   data_sram_en;
   logic [3:0]             data_sram_we;
   logic [31:0]            data_sram_addr;
   logic [31:0]            data_sram_wdata;

   modport master (
      input  ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
      output EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, EX_dest, EX_is_load,
             data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
   );

   modport slave (
      output ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
      input  EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus, EX_dest, EX_is_load,
             data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
   );

endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Only compiled when EX_DIV_EN is defined.
// Ports: clk, reset (async, active-low), start (level, sampled in IDLE),
//        signed_op, a (dividend), b (divisor), ack (result consumed),
//        busy, done, quotient, remainder (valid while done).
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// BUSY  | one restoring step per cycle, DIV_ITER steps
// DONE  | results held until ack
`ifdef EX_DIV_EN
module div_iter
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ack,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   div_state_e  state, state_nxt;
   logic [4:0]  count;
   logic [31:0] q_r, r_r, d_r;
   logic        q_neg, r_neg;
   logic [31:0] a_abs, b_abs;
   logic [32:0] r_shift;

   // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
   assign a_abs   = (signed_op && a[31]) ? -a : a;
   assign b_abs   = (signed_op && b[31]) ? -b : b;
   assign r_shift = {r_r, q_r[31]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= DIV_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         DIV_IDLE: if (start) state_nxt = DIV_BUSY;
         DIV_BUSY: if (count == 5'(DIV_ITER - 1)) state_nxt = DIV_DONE;
         DIV_DONE: if (ack) state_nxt = DIV_IDLE;
         default:  state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 5'd0;
      end else if (state == DIV_IDLE && start) begin
         count <= 5'd0;
      end else if (state == DIV_BUSY) begin
         count <= count + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == DIV_IDLE && start) begin
         q_r   <= a_abs;
         r_r   <= 32'd0;
         d_r   <= b_abs;
         // divide-by-zero keeps the all-ones quotient unsigned-looking
         q_neg <= signed_op && (a[31] ^ b[31]) && (b != 32'd0);
         r_neg <= signed_op && a[31];
      end else if (state == DIV_BUSY) begin
         if (r_shift >= {1'b0, d_r}) begin
            r_r <= 32'(r_shift - {1'b0, d_r});
            q_r <= {q_r[30:0], 1'b1};
         end else begin
            r_r <= r_shift[31:0];
            q_r <= {q_r[30:0], 1'b0};
         end
      end
   end

   assign busy      = (state == DIV_BUSY);
   assign done      = (state == DIV_DONE);
   assign quotient  = q_neg ? -q_r : q_r;
   assign remainder = r_neg ? -r_r : r_r;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage LoongArch pipeline.  Latches the ID->EX bus,
// computes the ALU result, runs div/mod through div_iter (stalling the pipe),
// and issues the data SRAM request in the cycle the instruction moves to ME.
// Ports: clk, reset (async, active-low), bus (ex_stage_if.master: ID/ME
//        handshakes, ID->EX and EX->ME buses, hazard taps, SRAM request).
// Build option: EX_DIV_EN instantiates the divider; without it ops 12-15
//               return 0 and every op is single-cycle.
module ex_stage
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   ex_stage_if.master  bus
);

   logic        ex_valid;
   logic [31:0] pc_r, src1_r, src2_r, rkd_r;
   alu_op_e     op_r;
   logic        mem_we_r, res_mem_r, gr_we_r;
   logic [4:0]  dest_r;
   logic        ready_go, fire;
   logic [31:0] alu_res, div_res;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               ex_valid <= 1'b0;
      else if (bus.EX_Allow_in) ex_valid <= bus.ID_to_EX_Valid;
   end

   always_ff @(posedge clk) begin
      if (bus.ID_to_EX_Valid && bus.EX_Allow_in) begin
         pc_r      <= bus.ID_to_EX_Bus[ID_PC_LSB +: 32];
         op_r      <= alu_op_e'(bus.ID_to_EX_Bus[ID_OP_LSB +: 4]);
         src1_r    <= bus.ID_to_EX_Bus[ID_SRC1_LSB +: 32];
         src2_r    <= bus.ID_to_EX_Bus[ID_SRC2_LSB +: 32];
         rkd_r     <= bus.ID_to_EX_Bus[ID_RKD_LSB +: 32];
         mem_we_r  <= bus.ID_to_EX_Bus[ID_MEM_WE_BIT];
         res_mem_r <= bus.ID_to_EX_Bus[ID_RES_MEM_BIT];
         gr_we_r   <= bus.ID_to_EX_Bus[ID_GR_WE_BIT];
         dest_r    <= bus.ID_to_EX_Bus[4:0];
      end
   end

`ifdef EX_DIV_EN
   logic        is_div, div_busy, div_done;
   logic [31:0] div_quo, div_rem;

   assign is_div = is_div_op(op_r);

   div_iter u_div_iter (
      .clk       (clk),
      .reset     (reset),
      .start     (ex_valid && is_div),
      .signed_op (op_r == ALU_OP_DIV || op_r == ALU_OP_MOD),
      .a         (src1_r),
      .b         (src2_r),
      .ack       (fire),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign div_res  = (op_r == ALU_OP_MOD || op_r == ALU_OP_MODU) ? div_rem : div_quo;
   assign ready_go = !is_div || div_done;
`else
   assign div_res  = 32'd0;
   assign ready_go = 1'b1;
`endif

   always_comb begin
      alu_res = 32'd0;
      unique case (op_r)
         ALU_OP_ADD:  alu_res = src1_r + src2_r;
         ALU_OP_SUB:  alu_res = src1_r - src2_r;
         ALU_OP_SLT:  alu_res = {31'd0, $signed(src1_r) < $signed(src2_r)};
         ALU_OP_SLTU: alu_res = {31'd0, src1_r < src2_r};
         ALU_OP_AND:  alu_res = src1_r & src2_r;
         ALU_OP_OR:   alu_res = src1_r | src2_r;
         ALU_OP_NOR:  alu_res = ~(src1_r | src2_r);
         ALU_OP_XOR:  alu_res = src1_r ^ src2_r;
         ALU_OP_SLL:  alu_res = src1_r << src2_r[4:0];
         ALU_OP_SRL:  alu_res = src1_r >> src2_r[4:0];
         ALU_OP_SRA:  alu_res = $signed(src1_r) >>> src2_r[4:0];
         ALU_OP_LUI:  alu_res = src2_r;
         ALU_OP_DIV, ALU_OP_MOD, ALU_OP_DIVU, ALU_OP_MODU: alu_res = div_res;
         default:     alu_res = 32'd0;
      endcase
   end

   assign bus.EX_Allow_in    = !ex_valid || (ready_go && bus.ME_Allow_in);
   assign bus.EX_to_ME_Valid = ex_valid && ready_go;
   assign fire               = bus.EX_to_ME_Valid && bus.ME_Allow_in;

   // Data outputs are gated by ex_valid so a reset zeroes them at once even
   // though the latched fields themselves are not reset.
   assign bus.EX_to_ME_Bus    = ex_valid ? {pc_r, alu_res, res_mem_r, gr_we_r, dest_r} : '0;
   assign bus.EX_dest         = ex_valid ? dest_r : 5'd0;
   assign bus.EX_is_load      = ex_valid && res_mem_r;
   assign bus.data_sram_en    = fire && (mem_we_r || res_mem_r);
   assign bus.data_sram_we    = {4{fire && mem_we_r}};
   assign bus.data_sram_addr  = ex_valid ? alu_res : 32'd0;
   assign bus.data_sram_wdata = ex_valid ? rkd_r : 32'd0;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
   import cpu_defs::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_stage_if bus();

   ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] result;
      logic [31:0] rkd;
      logic        mem_we;
      logic        res_mem;
      logic        gr_we;
      logic [4:0]  dest;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        pend;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        accepted;
   logic [31:0] pc_ctr = 32'h1c00_0000;

   task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

`ifdef EX_DIV_EN
   function automatic logic [31:0] div_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b; r = a % b;
      end
      return op[0] ? r : q;
   endfunction
`endif

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ext;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a + ~b + 32'd1;
         4'd2:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         4'd3:  return (a < b) ? 32'd1 : 32'd0;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return ~a & ~b;
         4'd7:  return (a | b) & ~(a & b);
         4'd8:  begin ext = {32'd0, a} << b[4:0]; return ext[31:0]; end
         4'd9:  begin ext = {32'd0, a} >> b[4:0]; return ext[31:0]; end
         4'd10: begin ext = {{32{a[31]}}, a} >> b[4:0]; return ext[31:0]; end
         4'd11: return b;
         default: begin
`ifdef EX_DIV_EN
            return div_model(op, a, b);
`else
            return 32'd0;
`endif
         end
      endcase
   endfunction

   // One clock: settle, score a fire if any, record an acceptance, advance.
   task automatic cycle();
      exp_t e;
      #1;
      if (bus.EX_to_ME_Valid && bus.ME_Allow_in) begin
         chk("sb_nonempty_at_fire", 71'(sb.size() != 0), 71'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latency", 71'(cyc - e.acc_cyc), 71'(e.lat));
            chk("ex_to_me_bus", bus.EX_to_ME_Bus, {e.pc, e.result, e.res_mem, e.gr_we, e.dest});
            chk("sram_en", 71'(bus.data_sram_en), 71'(e.mem_we || e.res_mem));
            chk("sram_we", 71'(bus.data_sram_we), 71'({4{e.mem_we}}));
            chk("sram_addr", 71'(bus.data_sram_addr), 71'(e.result));
            chk("sram_wdata", 71'(bus.data_sram_wdata), 71'(e.rkd));
            chk("ex_dest", 71'(bus.EX_dest), 71'(e.dest));
            chk("ex_is_load", 71'(bus.EX_is_load), 71'(e.res_mem));
         end
      end else begin
         chk("sram_idle", 71'(bus.data_sram_en), 71'(0));
      end
      if (bus.ID_to_EX_Valid && bus.EX_Allow_in && reset === 1'b1) begin
         pend.acc_cyc = cyc;
         sb.push_back(pend);
         accepted = 1'b1;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] rkd, input logic mw, input logic rm,
                       input logic [4:0] dest, input int lat);
      pend.pc      = pc_ctr;
      pend.result  = model(op, s1, s2);
      pend.rkd     = rkd;
      pend.mem_we  = mw;
      pend.res_mem = rm;
      pend.gr_we   = !mw;
      pend.dest    = dest;
      pend.lat     = lat;
      pc_ctr       = pc_ctr + 32'd4;
      bus.ID_to_EX_Valid = 1'b1;
      bus.ID_to_EX_Bus   = {pend.pc, op, s1, s2, rkd, mw, rm, !mw, dest};
      accepted = 1'b0;
      for (int i = 0; i < 100 && !accepted; i++) cycle();
      chk("accepted", 71'(accepted), 71'(1));
      bus.ID_to_EX_Valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) cycle();
      chk("drained", 71'(sb.size()), 71'(0));
   endtask

   task automatic check_zeroed(input string tag);
      chk({tag, "_valid"}, 71'(bus.EX_to_ME_Valid), 71'(0));
      chk({tag, "_sram_en"}, 71'(bus.data_sram_en), 71'(0));
      chk({tag, "_dest"}, 71'(bus.EX_dest), 71'(0));
      chk({tag, "_is_load"}, 71'(bus.EX_is_load), 71'(0));
      chk({tag, "_bus"}, bus.EX_to_ME_Bus, 71'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.ID_to_EX_Valid = 1'b0;
      bus.ID_to_EX_Bus   = '0;
      bus.ME_Allow_in    = 1'b1;

      // reset state
      cycle();
      cycle();
      check_zeroed("reset");
      chk("reset_allow_in", 71'(bus.EX_Allow_in), 71'(1));
      reset = 1'b1;
      cycle();

      // ADD overflow into the sign bit, single-cycle
      send(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd3, 1);
      drain();

      // back-to-back ALU ops
      send(4'd1,  32'd5,        32'd7,        32'd0, 1'b0, 1'b0, 5'd1,  1);
      send(4'd2,  32'hFFFF_FFFF, 32'd1,       32'd0, 1'b0, 1'b0, 5'd2,  1);
      send(4'd3,  32'hFFFF_FFFF, 32'd1,       32'd0, 1'b0, 1'b0, 5'd4,  1);
      send(4'd4,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 1'b0, 1'b0, 5'd5, 1);
      send(4'd5,  32'hF000_0001, 32'h0000_0F10, 32'd0, 1'b0, 1'b0, 5'd6, 1);
      send(4'd6,  32'h1234_0000, 32'h0000_5678, 32'd0, 1'b0, 1'b0, 5'd7, 1);
      send(4'd7,  32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0, 5'd8, 1);
      send(4'd8,  32'h8000_0003, 32'd36,        32'd0, 1'b0, 1'b0, 5'd9, 1);
      send(4'd9,  32'h8000_0000, 32'd31,        32'd0, 1'b0, 1'b0, 5'd10, 1);
      send(4'd10, 32'h8000_0000, 32'd4,         32'd0, 1'b0, 1'b0, 5'd11, 1);
      send(4'd11, 32'd0,        32'hABCD_E000,  32'd0, 1'b0, 1'b0, 5'd12, 1);
      send(4'd0,  32'h0000_2000, 32'd8,         32'd0, 1'b0, 1'b1, 5'd13, 1);
      drain();

      // store held by ME for 3 cycles
      send(4'd0, 32'h0000_1000, 32'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 4);
      bus.ME_Allow_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_allow_in", 71'(bus.EX_Allow_in), 71'(0));
         chk("stall_valid", 71'(bus.EX_to_ME_Valid), 71'(1));
         cycle();
      end
      bus.ME_Allow_in = 1'b1;
      drain();
      cycle();

`ifdef EX_DIV_EN
      send(4'd12, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 1'b0, 5'd14, 34);
      drain();
      send(4'd13, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 1'b0, 5'd15, 34);
      send(4'd14, 32'h0000_5678, 32'd0,         32'd0, 1'b0, 1'b0, 5'd16, 34);
      send(4'd15, 32'h0000_1234, 32'd0,         32'd0, 1'b0, 1'b0, 5'd17, 34);
      send(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd18, 34);
      send(4'd15, 32'd1000,      32'd7,         32'd0, 1'b0, 1'b0, 5'd19, 34);
      drain();

      // reset during the divide's busy phase
      send(4'd14, 32'd100, 32'd3, 32'd0, 1'b0, 1'b0, 5'd9, 34);
      for (int i = 0; i < 10; i++) cycle();
`else
      // without the divider, div/mod ops are single-cycle and return 0
      send(4'd12, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 1'b0, 5'd14, 1);
      send(4'd13, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 1'b0, 5'd15, 1);
      send(4'd14, 32'h0000_5678, 32'd0,         32'd0, 1'b0, 1'b0, 5'd16, 1);
      send(4'd15, 32'h0000_1234, 32'd0,         32'd0, 1'b0, 1'b0, 5'd17, 1);
      drain();

      // reset while a load is about to issue its SRAM request
      send(4'd0, 32'h0000_3000, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9, 1);
      #1;
      chk("pre_reset_sram_en", 71'(bus.data_sram_en), 71'(1));
`endif
      #1;
      reset = 1'b0;
      #1;
      check_zeroed("abort");
      sb.delete();
      @(negedge clk);
      cyc++;
      reset = 1'b1;
      cycle();
      send(4'd0, 32'h0000_0010, 32'h0000_0020, 32'd0, 1'b0, 1'b0, 5'd21, 1);
      drain();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage LoongArch pipeline, between the ID and ME stages. It latches the ID->EX bus and computes the ALU result. It runs a 32-iteration divider FSM for div/mod ops, stalling the pipe while it works. It issues the data SRAM request in the cycle it hands over to ME, and produces the 71-bit EX->ME bus that ME consumes.

Parameters:
DIV_ITER, 32, divider iterations (one quotient bit per cycle); fixed at 32, it exists only for documentation.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
ID_to_EX_Valid  input  1  ID holds a valid instruction
ME_Allow_in  input  1  ME can accept
EX_Allow_in  output  1  EX can accept
ID_to_EX_Bus  input  140  {pc[139:108], alu_op[107:104], src1[103:72], src2[71:40], rkd_value[39:8], mem_we[7], res_from_mem[6], gr_we[5], dest[4:0]}
EX_to_ME_Valid  output  1  EX output valid
EX_to_ME_Bus  output  71  {pc[70:39], alu_result[38:7], res_from_mem[6], gr_we[5], dest[4:0]}
EX_dest  output  5  dest gated by EX_Valid, for hazard detection
EX_is_load  output  1  res_from_mem && EX_Valid
data_sram_en  output  1  SRAM request
data_sram_we  output  4  byte write enables
data_sram_addr  output  32  alu_result
data_sram_wdata  output  32  rkd_value

Behaviour:
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 NOR, 7 XOR
  - 8 SLL, 9 SRL, 10 SRA, shift amount src2[4:0]
  - 11 LUI: result = src2
  - 12 DIV, 13 MOD (signed); 14 DIVU, 15 MODU
- Handshake:
  - EX_ReadyGO = !is_div || div_state==DONE.
  - EX_Allow_in = !EX_Valid || (EX_ReadyGO && ME_Allow_in).
  - EX_to_ME_Valid = EX_Valid && EX_ReadyGO.
  - fire = EX_to_ME_Valid && ME_Allow_in.
- Registers:
  - EX_Valid resets to 0. When EX_Allow_in is high, EX_Valid <= ID_to_EX_Valid.
  - Bus fields load when ID_to_EX_Valid && EX_Allow_in. They are not reset.
- Non-div ops: combinational, zero added latency; ReadyGO=1.
- SRAM request, issued only at fire, one request per instruction (ME samples rdata in the following cycle):
  - data_sram_en = fire && (mem_we || res_from_mem)
  - data_sram_we = {4{fire && mem_we}}
- Divider FSM (IDLE, BUSY, DONE):
  - IDLE -> BUSY when EX_Valid && is_div. Latch |src1|, |src2| (sign-aware for 12/13), result signs, count=0.
  - BUSY: restoring step per cycle, count++. After the step with count==31, go to DONE.
  - DONE: ReadyGO=1. Go to IDLE on fire. Hold DONE while ME stalls.
  - Div occupancy with ME ready: 34 cycles (1 IDLE, 32 BUSY, 1 DONE/fire).
  - Signed results: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; MOD/MODU -> src1.
  - 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0.
  - Bus fields are not reloaded while in BUSY or DONE, because EX_Allow_in=0.
- Reset:
  - Asynchronous assertion: EX_Valid=0, FSM=IDLE, count=0.
  - All outputs go to 0 immediately, including a reset that aborts a divide in progress.
  - Deassertion resumes cleanly from IDLE.

Optional Feature:
EX_DIV_EN
- Defined: divider FSM instantiated, ops 12-15 behave as above.
- Undefined: no divider logic, ops 12-15 yield alu_result=0, ReadyGO is constant 1, and every op is single-cycle.

Decomposition:
- Shared package/header cpu_defs: ALU_OP_* codes (4-bit), bus widths ID2EX_BUS_W=140 and EX2ME_BUS_W=71, field-offset constants.
- Sub-module div_iter:
  - Inputs: clk, reset, start, signed_op, a, b, ack.
  - Outputs: busy, done, quotient, remainder.
  - Holds the FSM.
  - ex_stage instantiates it under EX_DIV_EN.

Test Plan:
- ADD src1=0x7FFFFFFF, src2=1, ME ready -> next cycle EX_to_ME_Bus[38:7]=0x80000000, EX_to_ME_Valid=1, data_sram_en=0.
- Store (mem_we=1, ALU ADD src1=0x1000, src2=4, rkd=0xDEADBEEF) with ME_Allow_in held low 3 cycles:
  - while stalled: data_sram_en=0, EX_Allow_in=0
  - on release: data_sram_en=1, we=4'hF, addr=0x1004, wdata=0xDEADBEEF for exactly one cycle.
- DIV src1=-7 (0xFFFFFFF9), src2=2:
  - EX_to_ME_Valid low 33 cycles, high in the 34th with result 0xFFFFFFFD
  - MOD of the same operands gives 0xFFFFFFFF.
- DIVU by 0 and MODU src1=0x1234 by 0 -> 0xFFFFFFFF and 0x1234. Signed 0x80000000/0xFFFFFFFF -> 0x80000000.
- Reset driven low at BUSY cycle 10 -> EX_Valid, EX_to_ME_Valid, data_sram_en=0 immediately. After release, a new ADD completes in 1 cycle with the correct result.
- Build without EX_DIV_EN, DIV op -> result 0 in 1 cycle, ReadyGO never low.
